// File: rtl/mdl_stxserial.sv
// Purpose: device-model transmit serializer; 40-bit encoded words -> serial bit
//          stream, with SYNC fill and an ALIGN pair every ALIGN_INTERVAL words.
// Latency: an accepted word's bit 39 is on o_tx the cycle after the accepting edge.
// Backpressure: o_ready pulses only on the last bit of a word whose successor
//          is a data slot; with i_valid low at that edge a SYNC word is sent.
//
// Ports:
//   i_txclk       bit clock, one serial bit per rising edge
//   i_reset       synchronous active-high reset
//   i_link_up     serialization enable; low returns to idle and drops the word
//   i_valid/i_data  word offered for transmission (bit 39 goes out first)
//   o_ready       combinational accept strobe
//   o_tx          serial bit (MSB of the shift register)
//   o_word_start  high while o_tx carries bit 39 of a word
//   o_is_align    high for all 40 bits of an ALIGN word
module mdl_stxserial #(
  // Word width in encoded bits; only 40 is supported.
  parameter int P_BITS         = 40,
  // Words per period: one ALIGN pair plus ALIGN_INTERVAL-2 data/SYNC words.
  parameter int ALIGN_INTERVAL = 256
) (
  input  logic              i_txclk,
  input  logic              i_reset,
  input  logic              i_link_up,
  input  logic              i_valid,
  input  logic [P_BITS-1:0] i_data,
  output logic              o_ready,
  output logic              o_tx,
  output logic              o_word_start,
  output logic              o_is_align
);

  // D21.5 D21.5 D21.4 K28.3
  localparam logic [39:0] SYNC_P  = {10'b1010101010, 10'b1010101010,
                                     10'b1010101101, 10'b0011110011};
  // K28.5 D10.2 D10.2 D27.3
  localparam logic [39:0] ALIGN_P = {10'b0011111010, 10'b0101010101,
                                     10'b0101010101, 10'b1101100011};

  // State names the word currently on the wire.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ALIGN0 = 2'd1;
  localparam logic [1:0] S_ALIGN1 = 2'd2;
  localparam logic [1:0] S_DATA   = 2'd3;

  // Index of the last data word in a period (wcnt runs 0..WCNT_LAST).
  localparam logic [15:0] WCNT_LAST = 16'(ALIGN_INTERVAL - 3);

  logic [1:0]  state;
  logic [39:0] sreg;
  logic [5:0]  bit_cnt;
  logic [15:0] wcnt;
  logic        word_start_q;
  logic        is_align_q;

  logic        word_end;
  logic        data_slot;
  logic [39:0] data_word;

  assign word_end  = (bit_cnt == 6'd39);

  // The word following the current one is a data/SYNC slot.
  assign data_slot = (state == S_ALIGN1) ||
                     ((state == S_DATA) && (wcnt < WCNT_LAST));

  assign data_word = i_valid ? i_data : SYNC_P;

  // Link-down and reset both suppress acceptance on the same edge.
  assign o_ready = !i_reset && i_link_up && word_end && data_slot;

  always_ff @(posedge i_txclk) begin
    if (i_reset || !i_link_up) begin
      // Any in-flight word is discarded; a later link-up restarts from ALIGN.
      state        <= S_IDLE;
      sreg         <= '0;
      bit_cnt      <= '0;
      wcnt         <= '0;
      word_start_q <= 1'b0;
      is_align_q   <= 1'b0;
    end else if (state == S_IDLE) begin
      state        <= S_ALIGN0;
      sreg         <= ALIGN_P;
      bit_cnt      <= '0;
      wcnt         <= '0;
      word_start_q <= 1'b1;
      is_align_q   <= 1'b1;
    end else if (word_end) begin
      bit_cnt      <= '0;
      word_start_q <= 1'b1;
      case (state)
        S_ALIGN0: begin
          state      <= S_ALIGN1;
          sreg       <= ALIGN_P;
          is_align_q <= 1'b1;
        end
        S_ALIGN1: begin
          state      <= S_DATA;
          sreg       <= data_word;
          wcnt       <= '0;
          is_align_q <= 1'b0;
        end
        default: begin
          if (wcnt < WCNT_LAST) begin
            sreg       <= data_word;
            wcnt       <= wcnt + 16'd1;
            is_align_q <= 1'b0;
          end else begin
            state      <= S_ALIGN0;
            sreg       <= ALIGN_P;
            is_align_q <= 1'b1;
          end
        end
      endcase
    end else begin
      sreg         <= {sreg[38:0], 1'b0};
      bit_cnt      <= bit_cnt + 6'd1;
      word_start_q <= 1'b0;
    end
  end

  assign o_tx         = sreg[39];
  assign o_word_start = word_start_q;
  assign o_is_align   = is_align_q;

endmodule

// File: tb/tb_mdl_stxserial.sv
module tb_mdl_stxserial;

  localparam int AI = 8;
  localparam logic [39:0] ALIGN_W = 40'b0011111010_0101010101_0101010101_1101100011;
  localparam logic [39:0] SYNC_W  = 40'b1010101010_1010101010_1010101101_0011110011;
  localparam logic [39:0] FIRST_W = 40'hA5_5A0F_F0C3;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_link_up = 1'b0;
  logic        i_valid = 1'b0;
  logic [39:0] i_data = '0;
  logic        o_ready, o_tx, o_word_start, o_is_align;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;
  logic cap_en = 1'b0;
  logic rx_en  = 1'b0;

  always #5 clk = ~clk;

  mdl_stxserial #(.P_BITS(40), .ALIGN_INTERVAL(AI)) dut (
    .i_txclk     (clk),
    .i_reset     (i_reset),
    .i_link_up   (i_link_up),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_tx        (o_tx),
    .o_word_start(o_word_start),
    .o_is_align  (o_is_align)
  );

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) begin
      if (n_err < 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      n_err++;
    end
  endtask

  // Reference model: position in the stream since link-up. Word index
  // modulo AI gives the slot; slots 0 and 1 are ALIGN, the rest data/SYNC.
  logic        m_active = 1'b0;
  int          m_pos = 0;
  logic [39:0] m_word = '0;

  always @(posedge clk) begin
    int np;
    int slot;
    if (i_reset) begin
      m_active <= 1'b0;
      m_pos    <= 0;
    end else if (!i_link_up) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      m_active <= 1'b1;
      m_pos    <= 0;
      m_word   <= ALIGN_W;
    end else begin
      np = m_pos + 1;
      if (np % 40 == 0) begin
        slot = (np / 40) % AI;
        if (slot < 2)     m_word <= ALIGN_W;
        else if (i_valid) m_word <= i_data;
        else              m_word <= SYNC_W;
      end
      m_pos <= np;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    int   off;
    int   widx;
    logic e_tx, e_ws, e_al, e_rdy;
    if (chk_en) begin
      off   = m_pos % 40;
      widx  = m_pos / 40;
      e_tx  = m_active ? m_word[39 - off] : 1'b0;
      e_ws  = m_active && (off == 0);
      e_al  = m_active && ((widx % AI) < 2);
      e_rdy = !i_reset && i_link_up && m_active && (off == 39) && (((widx + 1) % AI) >= 2);
      chk("o_tx",         {39'b0, o_tx},         {39'b0, e_tx});
      chk("o_word_start", {39'b0, o_word_start}, {39'b0, e_ws});
      chk("o_is_align",   {39'b0, o_is_align},   {39'b0, e_al});
      chk("o_ready",      {39'b0, o_ready},      {39'b0, e_rdy});
    end
  end

  // Capture of raw outputs for directed literal checks.
  logic txq[$];
  logic rdyq[$];
  logic wsq[$];
  logic alq[$];
  always @(negedge clk) begin
    if (cap_en) begin
      txq.push_back(o_tx);
      rdyq.push_back(o_ready);
      wsq.push_back(o_word_start);
      alq.push_back(o_is_align);
    end
  end

  // Word deserializer keyed on o_word_start; keeps only small counter values.
  logic [39:0] rxq[$];
  logic [39:0] rx_acc = '0;
  int          rx_n = 0;
  always @(negedge clk) begin
    if (o_word_start) begin
      rx_acc = {39'b0, o_tx};
      rx_n   = 1;
    end else if (rx_n > 0) begin
      rx_acc = {rx_acc[38:0], o_tx};
      rx_n++;
    end
    if (rx_n == 40) begin
      if (rx_en && rx_acc < 40'h1_0000) rxq.push_back(rx_acc);
      rx_n = 0;
    end
  end

  function automatic logic [39:0] cap_word(input int k);
    logic [39:0] w;
    w = '0;
    for (int i = 0; i < 40; i++) w = {w[38:0], txq[40 * k + i]};
    return w;
  endfunction

  task automatic clear_cap();
    txq.delete(); rdyq.delete(); wsq.delete(); alq.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int ws_cnt;
  int first_rdy;
  int bad;
  logic hs;
  logic [39:0] d;
  logic found;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(1);
    chk_en = 1'b1;

    // Reset held with link up: outputs stay quiet.
    i_link_up = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx",    {39'b0, o_tx},         40'h0);
      chk("rst_ready", {39'b0, o_ready},      40'h0);
      chk("rst_ws",    {39'b0, o_word_start}, 40'h0);
      tick(1);
    end

    // Idle fill: ALIGN, ALIGN, then SYNC.
    i_reset = 1'b0;
    i_valid = 1'b0;
    clear_cap();
    @(posedge clk);
    cap_en = 1'b1;
    tick(200);
    cap_en = 1'b0;
    chk("fill_w0", cap_word(0), ALIGN_W);
    chk("fill_w1", cap_word(1), ALIGN_W);
    chk("fill_w2", cap_word(2), SYNC_W);
    chk("fill_w4", cap_word(4), SYNC_W);
    chk("fill_al79", {39'b0, alq[79]}, 40'h1);
    chk("fill_al80", {39'b0, alq[80]}, 40'h0);
    ws_cnt = 0;
    foreach (wsq[i]) if (wsq[i]) ws_cnt++;
    chk("fill_ws_count", 40'(ws_cnt), 40'd5);

    i_link_up = 1'b0;
    tick(3);

    // First data word and ALIGN insertion with continuous valid.
    i_valid   = 1'b1;
    i_data    = FIRST_W;
    i_link_up = 1'b1;
    clear_cap();
    @(posedge clk);
    cap_en = 1'b1;
    for (int c = 0; c < 720; c++) begin
      @(negedge clk);
      hs = o_ready;
      tick(1);
      if (hs) i_data = i_data + 40'd1;
    end
    cap_en = 1'b0;
    first_rdy = -1;
    foreach (rdyq[i]) if (rdyq[i] && first_rdy < 0) first_rdy = i;
    chk("first_ready_edge", 40'(first_rdy + 1), 40'd80);
    chk("data_w2",  cap_word(2),  FIRST_W);
    chk("data_w3",  cap_word(3),  FIRST_W + 40'd1);
    chk("data_w7",  cap_word(7),  FIRST_W + 40'd5);
    chk("align_w8", cap_word(8),  ALIGN_W);
    chk("align_w9", cap_word(9),  ALIGN_W);
    chk("data_w10", cap_word(10), FIRST_W + 40'd6);
    chk("align_w16", cap_word(16), ALIGN_W);
    chk("align_w17", cap_word(17), ALIGN_W);
    chk("rdy_319", {39'b0, rdyq[319]}, 40'h0);
    chk("rdy_359", {39'b0, rdyq[359]}, 40'h0);
    chk("rdy_399", {39'b0, rdyq[399]}, 40'h1);
    ws_cnt = 0;
    foreach (wsq[i]) if (wsq[i]) ws_cnt++;
    chk("data_ws_count", 40'(ws_cnt), 40'd18);

    // Random backpressure with an incrementing payload.
    rxq.delete();
    rx_en  = 1'b1;
    d      = 40'h100;
    i_data = d;
    for (int c = 0; c < 1500; c++) begin
      i_valid = 1'($urandom % 2);
      @(negedge clk);
      hs = i_valid && o_ready;
      tick(1);
      if (hs) begin
        d      = d + 40'd1;
        i_data = d;
      end
    end
    i_valid = 1'b0;
    tick(100);
    rx_en = 1'b0;
    chk("rx_count", 40'(rxq.size()), d - 40'h100);
    bad = 0;
    foreach (rxq[i]) if (rxq[i] !== 40'h100 + 40'(i)) bad++;
    chk("rx_sequence_bad", 40'(bad), 40'd0);

    // Link drop in the middle of a data word.
    i_valid = 1'b1;
    i_data  = 40'h0123_4567_89;
    found   = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      if (m_active && (m_pos % 40 == 17) && ((m_pos / 40) % AI >= 2)) found = 1'b1;
      else tick(1);
    end
    chk("drop_point_found", {39'b0, found}, 40'h1);
    i_link_up = 1'b0;
    @(negedge clk);
    chk("drop_ready", {39'b0, o_ready}, 40'h0);
    tick(1);
    @(negedge clk);
    chk("drop_tx",    {39'b0, o_tx},         40'h0);
    chk("drop_ws",    {39'b0, o_word_start}, 40'h0);
    chk("drop_align", {39'b0, o_is_align},   40'h0);
    tick(9);
    i_link_up = 1'b1;
    clear_cap();
    @(posedge clk);
    cap_en = 1'b1;
    tick(120);
    cap_en = 1'b0;
    chk("restart_w0", cap_word(0), ALIGN_W);
    chk("restart_w1", cap_word(1), ALIGN_W);
    chk("restart_w2", cap_word(2), 40'h0123_4567_89);

    // Reset mid-word.
    i_reset = 1'b1;
    tick(1);
    @(negedge clk);
    chk("midrst_tx", {39'b0, o_tx},         40'h0);
    chk("midrst_ws", {39'b0, o_word_start}, 40'h0);
    i_reset = 1'b0;
    tick(50);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mdl_stxserial.md
MDL_STXSERIAL -- requirements
Module: mdl_stxserial

Purpose: device-model transmit serializer. Converts 40-bit encoded words into the serial bit stream consumed on the device COM/TX FSM's i_tx input. Inserts SYNC fill and periodic ALIGN pairs.

Interface
REQ-001 P_BITS, 40, word width in encoded bits; the only supported value is 40.
REQ-002 ALIGN_INTERVAL, 256, words per period: one ALIGN pair plus ALIGN_INTERVAL-2 data/SYNC words; legal range 4..65535.
REQ-003 SYNC_P, {D21.5, D21.5, D21.4, K28.3} as 10-bit codes 1010101010, 1010101010, 1010101101, 0011110011; idle fill word.
REQ-004 ALIGN_P, {K28.5, D10.2, D10.2, D27.3} as 10-bit codes 0011111010, 0101010101, 0101010101, 1101100011; alignment primitive.
REQ-005 i_txclk  input  1  bit clock; one serial bit per rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_link_up  input  1  serialization enable; driven from the link-layer-up indication.
REQ-008 i_valid  input  1  i_data holds a word to send.
REQ-009 i_data  input  40  encoded word; bit 39 is transmitted first.
REQ-010 o_ready  output  1  word accepted on this edge when i_valid is also high.
REQ-011 o_tx  output  1  registered serial bit.
REQ-012 o_word_start  output  1  registered; high while o_tx carries bit 39 of any word.
REQ-013 o_is_align  output  1  registered; high for all 40 bits of an ALIGN word.

Function
REQ-014 States are IDLE, ALIGN0, ALIGN1 and DATA. Internal registers: a 40-bit shift register sreg, a 6-bit bit counter bit_cnt, and a 16-bit word counter wcnt.
REQ-015 o_tx SHALL equal sreg[39]; at each non-boundary edge sreg SHALL shift left by one with zero fill.
REQ-016 A word boundary is any edge where bit_cnt==39, or an IDLE edge where i_link_up==1. At a boundary, bit_cnt returns to 0 and the next word loads into sreg.
REQ-017 IDLE: o_tx, o_word_start, o_is_align and o_ready all 0; bit_cnt and wcnt held at 0. When i_link_up is sampled 1, ALIGN_P is loaded and the state becomes ALIGN0.
REQ-018 ALIGN0 boundary: load ALIGN_P, go to ALIGN1.
REQ-019 ALIGN1 boundary: load the data word, go to DATA, clear wcnt to 0.
REQ-020 DATA boundary with wcnt < ALIGN_INTERVAL-3: load the data word, increment wcnt.
REQ-021 DATA boundary with wcnt == ALIGN_INTERVAL-3: load ALIGN_P, go to ALIGN0.
REQ-022 Loading "the data word" means i_data when i_valid==1, otherwise SYNC_P. SYNC words count toward wcnt exactly as data words do.
REQ-023 o_ready is combinational. It SHALL be 1 only when all of the following hold:
- i_link_up==1
- bit_cnt==39
- the word being loaded is a data word (per REQ-019/REQ-020)
REQ-024 A transfer occurs on an edge where i_valid and o_ready are both 1. Each accepted word is transmitted exactly once; no duplicates, no drops.
REQ-025 While not accepted, i_data may change freely; it is sampled only at the accepting edge.
REQ-026 o_word_start SHALL be 1 during the cycle following every boundary load. o_is_align SHALL be 1 for the 40 cycles following an ALIGN_P load.
REQ-027 Latency: an accepted word's bit 39 appears on o_tx in the cycle immediately after the accepting edge.
REQ-028 i_link_up sampled 0 in any non-IDLE state:
- next state IDLE; all outputs 0 the following cycle
- the in-flight word is discarded
- no acceptance on that edge (o_ready is 0)
REQ-029 A link-up after a drop SHALL restart with a fresh ALIGN pair.
REQ-030 wcnt SHALL never exceed ALIGN_INTERVAL-3 and never wraps.

Reset
REQ-031 i_reset sampled 1 SHALL force the following on the next edge, regardless of i_link_up or the current state, including mid-word:
- state IDLE
- sreg=0, bit_cnt=0, wcnt=0
- o_tx=0, o_word_start=0, o_is_align=0
REQ-032 o_ready SHALL be 0 while i_reset is 1.

Verification
REQ-033 Reset check: assert i_reset for 3 cycles with i_link_up=1 -> o_tx=0, o_ready=0, o_word_start=0 throughout, and the state is IDLE afterward.
REQ-034 Idle fill: raise i_link_up with i_valid=0 -> o_tx shows ALIGN_P, ALIGN_P, then SYNC_P repeated. o_word_start pulses every 40 cycles; o_is_align is high for the first 80 bits only.
REQ-035 First data: i_valid=1, i_data=40'hA5_5A0F_F0C3 from link-up -> o_ready first high at the 80th edge after the IDLE load (end of ALIGN1). The word appears MSB first on o_tx bits 80..119.
REQ-036 ALIGN insertion with ALIGN_INTERVAL=8:
- stream continuous data with i_valid=1
- after 6 data words, two ALIGN_P words follow
- o_ready stays 0 at the DATA->ALIGN0 and ALIGN0->ALIGN1 boundaries
- the pattern repeats every 320 bits
REQ-037 Backpressure: toggle i_valid randomly with incrementing i_data values -> received words are strictly incrementing with no gaps or repeats. SYNC_P appears wherever i_valid was 0 at a boundary.
REQ-038 Link drop: drop i_link_up at bit 17 of a data word, hold it low 10 cycles, then raise it -> o_tx=0 from the next cycle. The partial word is never resumed; the restart begins with ALIGN_P, ALIGN_P.
